cpu_sequencer: RTL
==================

# cpu_sequencer

Control-unit FSM for the 8-bit accumulator CPU. It fetches and decodes instructions and drives the one-hot control strobes for the ALU/accumulator, PC, IR, MAR and memory, all of which share `sysbus`. It consumes the ALU zero flag for conditional branches and holds on a memory wait handshake. It also maintains a saturating retired-instruction counter for debug.

## Interface
- `WORD_W`, 8, bus/word width
- `OP_W`, 3, opcode width (upper `OP_W` bits of IR)
- `CNT_W`, 16, retired-instruction counter width
- `clock`  in  1  rising-edge clock
- `n_reset`  in  1  reset, asynchronous, active-low
- `op`  in  OP_W  opcode from IR (valid from DECODE onward)
- `z_flag`  in  1  accumulator==0 from ALU
- `mem_ready`  in  1  memory access completes this cycle
- `PC_bus`, `Addr_bus`, `ACC_bus`  out  1 each  drive PC / IR address field / accumulator onto sysbus
- `load_PC`, `INC_PC`, `load_IR`, `load_MAR`  out  1 each  register load strobes
- `load_ACC`, `ALU_ACC`, `ALU_add`, `ALU_sub`, `ALU_xor`  out  1 each  ALU controls
- `CS`, `R_NW`  out  1 each  memory select; read=1 / write=0
- `halted`  out  1  sequencer in HALT
- `instr_count`  out  CNT_W  retired instructions, saturating

## Operation
- States: FETCH0, FETCH1, DECODE, EXEC, HALT. Outputs are a Moore decode of state, plus `op`/`z_flag` in DECODE/EXEC. Any strobe not listed for a state is 0.
- FETCH0: `PC_bus`, `load_MAR`, `INC_PC`, `load_PC` -> FETCH1.
- FETCH1: `CS`, `R_NW`, `load_IR` (memory drives sysbus).
  - Holds while `mem_ready`=0, with `load_IR` gated to 0.
  - On `mem_ready`=1 -> DECODE.
- DECODE, by `op`:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 XOR: `Addr_bus`, `load_MAR` -> EXEC.
  - 101 JMP: `Addr_bus`, `load_PC` -> FETCH0.
  - 110 BZ: if `z_flag`=1, `Addr_bus` and `load_PC`; else no strobes. Either way -> FETCH0.
  - 111 HALT: no strobes -> HALT.
- EXEC, by latched behaviour of `op`:
  - LOAD: `CS`, `R_NW`, `load_ACC`.
  - STORE: `ACC_bus`, `CS`, `R_NW`=0.
  - ADD/SUB/XOR: `CS`, `R_NW`, `load_ACC`, `ALU_ACC`, plus exactly one of `ALU_add`/`ALU_sub`/`ALU_xor`.
  - Holds while `mem_ready`=0, with `load_ACC` gated to 0. For STORE, `CS` and `ACC_bus` remain asserted during the hold.
  - On `mem_ready`=1 -> FETCH0.
- HALT: all strobes 0, `halted`=1. Leaves only on reset.
- Bus exclusivity invariant, every cycle: at most one of `PC_bus`, `Addr_bus`, `ACC_bus`, (`CS`&`R_NW`) is 1.
- `instr_count`: +1 on the clock edge that leaves EXEC, on the DECODE edge for JMP/BZ/HALT, and never otherwise. Saturates at 2^CNT_W-1 with no wrap.
- `z_flag` is sampled in the DECODE cycle only.

## Timing
- Reset asserted (asynchronous): state=FETCH0, `instr_count`=0, `halted`=0. All strobes are forced 0 while `n_reset`=0 (combinationally gated).
- First FETCH0 strobes appear in the cycle after `n_reset` deasserts.
- Latency with zero wait states:
  - LOAD/STORE/ADD/SUB/XOR: 4 cycles.
  - JMP/BZ: 3 cycles.
  - HALT: `halted`=1 in the 4th cycle after FETCH0.
- Each `mem_ready`=0 cycle in FETCH1 or EXEC adds exactly one cycle. `mem_ready` is ignored in all other states.
- Reset mid-instruction (any state, including a wait hold): state is abandoned immediately and no partial strobes are issued. Restart is from FETCH0 with the count cleared.
- `op` and `z_flag` changes outside DECODE/EXEC have no effect.

## Test plan
- Reset, then ADD (010), `mem_ready`=1: strobe sequence FETCH0, FETCH1, DECODE(`Addr_bus`,`load_MAR`), EXEC(`load_ACC`,`ALU_ACC`,`ALU_add`). `instr_count`=1 after 4 cycles.
- STORE (001) with `mem_ready` low for 2 EXEC cycles: EXEC lasts 3 cycles with `ACC_bus`=1, `CS`=1, `R_NW`=0 throughout. Total 6 cycles; count +1 only once.
- BZ (110) with `z_flag`=1: `Addr_bus`+`load_PC` in DECODE. With `z_flag`=0: no strobes in DECODE. Both take 3 cycles and retire.
- HALT (111): `halted`=1, all strobes 0 for 20 cycles, count frozen. Pulsing `n_reset` low returns to FETCH0 with `instr_count`=0.
- Reset asserted mid-EXEC of SUB: `load_ACC`/`ALU_sub` drop in the same cycle. After release, FETCH0 strobes resume and count=0.
- With `CNT_W`=4, run 20 JMPs: `instr_count` stops at 15. The bus-exclusivity assertion holds on every cycle of every test.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Control-unit FSM for the 8-bit accumulator CPU: fetch/decode/execute strobe
// generation with memory wait holds and a saturating retired-instruction counter.
module cpu_sequencer #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic             PC_bus,
  output logic             Addr_bus,
  output logic             ACC_bus,
  output logic             load_PC,
  output logic             INC_PC,
  output logic             load_IR,
  output logic             load_MAR,
  output logic             load_ACC,
  output logic             ALU_ACC,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             ALU_xor,
  output logic             CS,
  output logic             R_NW,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_o
);

  if (OP_W > WORD_W) begin : g_bad_op_w
    $error("cpu_sequencer: opcode field wider than the bus word");
  end

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BZ    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic pc_bus;
    logic addr_bus;
    logic acc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic load_mar;
    logic load_acc;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic alu_xor;
    logic cs;
    logic r_nw;
  } strobes_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            retire;
  strobes_t        raw, st;

  // State, latched opcode and counter registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_FETCH0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = mem_ready ? S_DECODE : S_FETCH1;
      S_DECODE: begin
        case (op)
          OP_JMP, OP_BZ: state_d = S_FETCH0;
          OP_HALT:       state_d = S_HALT;
          default:       state_d = S_EXEC;
        endcase
      end
      S_EXEC:   state_d = mem_ready ? S_FETCH0 : S_EXEC;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH0;
    endcase
  end

  // Retirement: EXEC completion, or in DECODE for instructions with no EXEC phase
  always_comb begin
    retire = 1'b0;
    op_d   = op_q;
    if (state_q == S_DECODE) begin
      op_d   = op;
      retire = (op == OP_JMP) || (op == OP_BZ) || (op == OP_HALT);
    end else if (state_q == S_EXEC) begin
      retire = mem_ready;
    end
    cnt_d = (retire && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Moore strobe decode, with op/z_flag in DECODE and latched op in EXEC
  always_comb begin
    raw = '0;
    case (state_q)
      S_FETCH0: begin
        raw.pc_bus   = 1'b1;
        raw.load_mar = 1'b1;
        raw.inc_pc   = 1'b1;
        raw.load_pc  = 1'b1;
      end
      S_FETCH1: begin
        raw.cs      = 1'b1;
        raw.r_nw    = 1'b1;
        raw.load_ir = mem_ready;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
            raw.addr_bus = 1'b1;
            raw.load_mar = 1'b1;
          end
          OP_JMP: begin
            raw.addr_bus = 1'b1;
            raw.load_pc  = 1'b1;
          end
          OP_BZ: begin
            raw.addr_bus = z_flag;
            raw.load_pc  = z_flag;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        raw.cs = 1'b1;
        case (op_q)
          OP_STORE: raw.acc_bus = 1'b1;
          OP_LOAD: begin
            raw.r_nw     = 1'b1;
            raw.load_acc = mem_ready;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            raw.r_nw     = 1'b1;
            raw.load_acc = mem_ready;
            raw.alu_acc  = 1'b1;
            raw.alu_add  = (op_q == OP_ADD);
            raw.alu_sub  = (op_q == OP_SUB);
            raw.alu_xor  = (op_q == OP_XOR);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Strobes are killed combinationally while reset is held
  assign st = n_reset ? raw : '0;

  assign PC_bus      = st.pc_bus;
  assign Addr_bus    = st.addr_bus;
  assign ACC_bus     = st.acc_bus;
  assign load_PC     = st.load_pc;
  assign INC_PC      = st.inc_pc;
  assign load_IR     = st.load_ir;
  assign load_MAR    = st.load_mar;
  assign load_ACC    = st.load_acc;
  assign ALU_ACC     = st.alu_acc;
  assign ALU_add     = st.alu_add;
  assign ALU_sub     = st.alu_sub;
  assign ALU_xor     = st.alu_xor;
  assign CS          = st.cs;
  assign R_NW        = st.r_nw;
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;
  assign state_o     = state_q;

endmodule
